// File: rtl/conv_window_gen.sv
// conv_window_gen: 3x3 sliding-window generator over a raster pixel stream.
// Two per-channel line buffers hold the previous two rows; a 3x3 shift window
// per channel collects columns, and each complete no-padding window is written
// to the downstream FIFO one cycle after the pixel that completes it.
module conv_window_gen #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned D          = 3,
  parameter int unsigned F          = 3,
  parameter int unsigned IMG_W      = 256,
  parameter int unsigned IMG_H      = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [D*DATA_WIDTH-1:0]      in_data,
  output logic                         in_ready,
  input  logic                         fifo_full,
  output logic                         win_write,
  output logic [D*F*F*DATA_WIDTH-1:0]  win_data,
  output logic                         frame_done
);

  localparam int unsigned PW = D * DATA_WIDTH;
  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  generate
    if (F != 3) begin : g_bad_f
      $error("conv_window_gen: only F=3 is supported");
    end
    if (IMG_W < F || IMG_H < F) begin : g_bad_img
      $error("conv_window_gen: image must be at least FxF");
    end
  endgenerate

  logic                  accept;
  logic                  complete;
  logic                  last_pix;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [PW-1:0]         lb0_mem [IMG_W];
  logic [PW-1:0]         lb1_mem [IMG_W];
  logic [PW-1:0]         lb0_rd, lb1_rd;
  logic [DATA_WIDTH-1:0] win_q [D][F][F];
  logic [DATA_WIDTH-1:0] win_d [D][F][F];
  logic                  win_write_q, win_write_d;
  logic                  frame_done_q, frame_done_d;
  logic [D*F*F*DATA_WIDTH-1:0] win_data_q, win_data_d;

  // Handshake, line-buffer read and raster position counters
  always_comb begin
    in_ready = ~fifo_full;
    accept   = in_valid & ~fifo_full;
    lb0_rd   = lb0_mem[col_q];
    lb1_rd   = lb1_mem[col_q];
    col_d    = col_q;
    row_d    = row_q;
    if (accept) begin
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        if (row_q == RW'(IMG_H - 1)) row_d = '0;
        else                         row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Window shift: older columns move left, new column enters at k=F-1
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int unsigned c = 0; c < D; c++) begin
        for (int unsigned r = 0; r < F; r++) begin
          for (int unsigned k = 0; k < F - 1; k++) begin
            win_d[c][r][k] = win_q[c][r][k+1];
          end
        end
        win_d[c][0][F-1] = lb1_rd[c*DATA_WIDTH +: DATA_WIDTH];
        win_d[c][1][F-1] = lb0_rd[c*DATA_WIDTH +: DATA_WIDTH];
        win_d[c][2][F-1] = in_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output strobe and packed window; stale RAM/window data is never exposed
  // because only positions with row>=2 and col>=2 produce a write
  always_comb begin
    complete     = accept && (col_q >= CW'(2)) && (row_q >= RW'(2));
    last_pix     = (col_q == CW'(IMG_W - 1)) && (row_q == RW'(IMG_H - 1));
    win_write_d  = complete;
    frame_done_d = complete && last_pix;
    win_data_d   = win_data_q;
    if (complete) begin
      for (int unsigned c = 0; c < D; c++) begin
        for (int unsigned r = 0; r < F; r++) begin
          for (int unsigned k = 0; k < F; k++) begin
            win_data_d[((c*F + r)*F + k)*DATA_WIDTH +: DATA_WIDTH] = win_d[c][r][k];
          end
        end
      end
    end
  end

  // Line buffers: uncleared RAM, one entry per column
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_mem[col_q] <= lb0_rd;
      lb0_mem[col_q] <= in_data;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      win_write_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_data_q   <= '0;
      for (int unsigned c = 0; c < D; c++) begin
        for (int unsigned r = 0; r < F; r++) begin
          for (int unsigned k = 0; k < F; k++) begin
            win_q[c][r][k] <= '0;
          end
        end
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_write_q  <= win_write_d;
      frame_done_q <= frame_done_d;
      win_data_q   <= win_data_d;
      win_q        <= win_d;
    end
  end

  assign win_write  = win_write_q;
  assign frame_done = frame_done_q;
  assign win_data   = win_data_q;

endmodule
